// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and types for the memory-mapped I/O controller
//
// Purpose : register offsets inside the I/O window, full-word write mask,
//           and the switch debounce FSM state encoding.
// Ports   : none (package).

package io_pkg;

  // Register offsets, taken from cpu_addr[3:2]
  localparam logic [1:0] OFF_SEG  = 2'd0;
  localparam logic [1:0] OFF_SW   = 2'd1;
  localparam logic [1:0] OFF_CYC  = 2'd2;
  localparam logic [1:0] OFF_RSVD = 2'd3;

  // Only full-word stores reach the I/O registers
  localparam logic [3:0] WFLAG_FULL = 4'hF;

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchronizer plus settle-time debounce for switches
//
// Purpose : brings the raw asynchronous switch vector into the clk_in domain
//           and only commits a new value once it has been steady for
//           DEB_CYCLES consecutive cycles.
// Ports   :
//   clk_in    in   1     system clock
//   reset     in   1     synchronous active-high reset
//   sw        in   SW_W  raw asynchronous switches
//   sw_stable out  SW_W  committed (debounced) switch value

module sw_debounce
  import io_pkg::*;
#(
  parameter int unsigned SW_W       = 16,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] sw_stable
);

  // Counter only needs to reach DEB_CYCLES-1
  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SW_W-1:0]  sw_s1_q;
  logic [SW_W-1:0]  sw_s2_q;
  logic [SW_W-1:0]  cand_q,   cand_d;
  logic [SW_W-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  deb_state_e       state_q,  state_d;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (sw_s2_q != stable_q) begin
          cand_d  = sw_s2_q;
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end
      SETTLING: begin
        if (sw_s2_q != cand_q) begin
          // Input moved again: restart the settle window on the new value
          cand_d = sw_s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = cand_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sw_stable = stable_q;

endmodule

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - memory-mapped I/O controller between CPU data port and dmem
//
// Purpose : decodes CPU data accesses; addresses with addr[31:16]==IO_BASE_HI
//           hit local registers (SEG, SW, CYC), everything else passes to
//           dmem. Read data is returned combinationally in the same cycle.
// Ports   :
//   clk_in    in   1     system clock
//   reset     in   1     synchronous active-high reset
//   cpu_addr  in   32    CPU data address
//   cpu_wdata in   32    CPU store data
//   cpu_w     in   1     CPU store strobe
//   cpu_r     in   1     CPU load strobe
//   cpu_wflag in   4     byte-lane write mask
//   cpu_rdata out  32    load data to CPU
//   dm_w      out  1     store strobe to dmem (suppressed on I/O hits)
//   dm_r      out  1     load strobe to dmem (suppressed on I/O hits)
//   dm_rdata  in   32    dmem read data
//   sw        in   SW_W  raw asynchronous switches
//   seg_data  out  32    value for the seg7x16 scanner
//   sw_stable out  SW_W  debounced switch value

module io_ctrl
  import io_pkg::*;
#(
  parameter logic [15:0] IO_BASE_HI = 16'h1002,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned SW_W       = 16
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  input  logic            cpu_w,
  input  logic            cpu_r,
  input  logic [3:0]      cpu_wflag,
  output logic [31:0]     cpu_rdata,
  output logic            dm_w,
  output logic            dm_r,
  input  logic [31:0]     dm_rdata,
  input  logic [SW_W-1:0] sw,
  output logic [31:0]     seg_data,
  output logic [SW_W-1:0] sw_stable
);

  logic        io_hit;
  logic [1:0]  reg_off;
  logic        io_wr;
  logic [31:0] seg_q, seg_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] io_rdata;
  logic        unused_addr_bits;

  // Window aliases every 16 bytes: only addr[3:2] selects a register
  assign io_hit  = (cpu_addr[31:16] == IO_BASE_HI);
  assign reg_off = cpu_addr[3:2];
  assign unused_addr_bits = ^{cpu_addr[15:4], cpu_addr[1:0]};

  // Partial-lane stores into the window are dropped entirely
  assign io_wr = cpu_w & io_hit & (cpu_wflag == WFLAG_FULL);

  assign dm_w = cpu_w & ~io_hit;
  assign dm_r = cpu_r & ~io_hit;

  sw_debounce #(
    .SW_W      (SW_W),
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .clk_in   (clk_in),
    .reset    (reset),
    .sw       (sw),
    .sw_stable(sw_stable)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      seg_q <= '0;
      cyc_q <= '0;
    end else begin
      seg_q <= seg_d;
      cyc_q <= cyc_d;
    end
  end

  always_comb begin
    seg_d = seg_q;
    cyc_d = cyc_q + 32'd1;
    if (io_wr) begin
      case (reg_off)
        OFF_SEG: seg_d = cpu_wdata;
        OFF_CYC: cyc_d = '0;  // clear wins over the increment
        default: ;
      endcase
    end
  end

  // Read mux uses pre-edge register contents; cpu_r is not needed to select
  always_comb begin
    io_rdata = '0;
    case (reg_off)
      OFF_SEG:  io_rdata = seg_q;
      OFF_SW:   io_rdata = 32'(sw_stable);
      OFF_CYC:  io_rdata = cyc_q;
      OFF_RSVD: io_rdata = '0;
      default:  io_rdata = '0;
    endcase
  end

  assign cpu_rdata = io_hit ? io_rdata : dm_rdata;
  assign seg_data  = seg_q;

endmodule

// File: tb/tb_io_ctrl.sv
// tb/tb_io_ctrl.sv - directed self-checking bench for io_ctrl

module tb_io_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_w;
  logic        cpu_r;
  logic [3:0]  cpu_wflag;
  logic [31:0] cpu_rdata;
  logic        dm_w;
  logic        dm_r;
  logic [31:0] dm_rdata;
  logic [15:0] sw;
  logic [31:0] seg_data;
  logic [15:0] sw_stable;

  int n_tests = 0;
  int n_fail  = 0;

  io_ctrl #(
    .IO_BASE_HI(16'h1002),
    .DEB_CYCLES(4),
    .SW_W      (16)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_w    (cpu_w),
    .cpu_r    (cpu_r),
    .cpu_wflag(cpu_wflag),
    .cpu_rdata(cpu_rdata),
    .dm_w     (dm_w),
    .dm_r     (dm_r),
    .dm_rdata (dm_rdata),
    .sw       (sw),
    .seg_data (seg_data),
    .sw_stable(sw_stable)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_addr = 32'h1002_0008; cpu_wdata = '0; cpu_w = 0; cpu_r = 0;
    cpu_wflag = 4'h0; dm_rdata = 32'h0; sw = 16'h0;
    tick(); tick();
    n_tests++;
    if (seg_data !== 32'h0) begin n_fail++; $display("FAIL reset_seg got %h want %h", seg_data, 32'h0); end
    n_tests++;
    if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL reset_sw got %h want %h", sw_stable, 16'h0); end
    n_tests++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cyc got %h want %h", cpu_rdata, 32'h0); end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    cpu_addr = 32'h1001_0000; cpu_w = 1; cpu_r = 1; cpu_wflag = 4'hF;
    cpu_wdata = 32'h5555_5555; dm_rdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (dm_w !== 1'b1) begin n_fail++; $display("FAIL pass_dm_w got %b want 1", dm_w); end
    n_tests++;
    if (dm_r !== 1'b1) begin n_fail++; $display("FAIL pass_dm_r got %b want 1", dm_r); end
    n_tests++;
    if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pass_rdata got %h want %h", cpu_rdata, 32'hDEAD_BEEF); end
    tick();
    cpu_w = 0; cpu_r = 0;
    n_tests++;
    if (seg_data !== 32'h0) begin n_fail++; $display("FAIL pass_seg got %h want %h", seg_data, 32'h0); end
  endtask

  task automatic test_seg_write();
    cpu_addr = 32'h1002_0000; cpu_wdata = 32'h1234_5678; cpu_w = 1; cpu_wflag = 4'hF;
    #1;
    n_tests++;
    if (dm_w !== 1'b0) begin n_fail++; $display("FAIL seg_dm_w got %b want 0", dm_w); end
    tick();
    cpu_w = 0; cpu_r = 1;
    #1;
    n_tests++;
    if (seg_data !== 32'h1234_5678) begin n_fail++; $display("FAIL seg_out got %h want %h", seg_data, 32'h1234_5678); end
    n_tests++;
    if (cpu_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL seg_read got %h want %h", cpu_rdata, 32'h1234_5678); end
    n_tests++;
    if (dm_r !== 1'b0) begin n_fail++; $display("FAIL seg_dm_r got %b want 0", dm_r); end
    cpu_r = 0;
  endtask

  task automatic test_partial_and_reserved();
    cpu_addr = 32'h1002_0000; cpu_wdata = 32'hCAFE_F00D; cpu_w = 1; cpu_wflag = 4'h3;
    #1;
    n_tests++;
    if (dm_w !== 1'b0) begin n_fail++; $display("FAIL partial_dm_w got %b want 0", dm_w); end
    tick();
    n_tests++;
    if (seg_data !== 32'h1234_5678) begin n_fail++; $display("FAIL partial_seg got %h want %h", seg_data, 32'h1234_5678); end
    cpu_addr = 32'h1002_000C; cpu_wflag = 4'hF;
    tick();
    cpu_w = 0;
    #1;
    n_tests++;
    if (seg_data !== 32'h1234_5678) begin n_fail++; $display("FAIL rsvd_seg got %h want %h", seg_data, 32'h1234_5678); end
    n_tests++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rsvd_read got %h want %h", cpu_rdata, 32'h0); end
  endtask

  task automatic test_alias_and_rw_same();
    cpu_addr = 32'h1002_0FF3; cpu_wdata = 32'h0BAD_F00D; cpu_w = 1; cpu_wflag = 4'hF;
    tick();
    n_tests++;
    if (seg_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL alias_seg got %h want %h", seg_data, 32'h0BAD_F00D); end
    cpu_addr = 32'h1002_0000; cpu_wdata = 32'h1111_2222; cpu_r = 1;
    #1;
    n_tests++;
    if (cpu_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rw_pre_read got %h want %h", cpu_rdata, 32'h0BAD_F00D); end
    tick();
    cpu_w = 0; cpu_r = 0;
    n_tests++;
    if (seg_data !== 32'h1111_2222) begin n_fail++; $display("FAIL rw_seg got %h want %h", seg_data, 32'h1111_2222); end
  endtask

  task automatic test_glitch();
    sw = 16'h0001;
    tick(); tick();
    sw = 16'h0000;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_tests++;
      if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL glitch_c%0d got %h want %h", k, sw_stable, 16'h0); end
    end
  endtask

  task automatic test_debounce_step();
    logic [15:0] exp;
    sw = 16'hA5A5;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k == 7) ? 16'hA5A5 : 16'h0000;
      n_tests++;
      if (sw_stable !== exp) begin n_fail++; $display("FAIL step_c%0d got %h want %h", k, sw_stable, exp); end
    end
    cpu_addr = 32'h1002_0004;
    #1;
    n_tests++;
    if (cpu_rdata !== 32'h0000_A5A5) begin n_fail++; $display("FAIL sw_read got %h want %h", cpu_rdata, 32'h0000_A5A5); end
  endtask

  task automatic test_cycle();
    logic [31:0] v1;
    cpu_addr = 32'h1002_0008; cpu_w = 0;
    #1;
    v1 = cpu_rdata;
    tick();
    n_tests++;
    if (cpu_rdata !== v1 + 32'd1) begin n_fail++; $display("FAIL cyc_inc got %h want %h", cpu_rdata, v1 + 32'd1); end
    cpu_w = 1; cpu_wflag = 4'hF; cpu_wdata = 32'hFFFF_FFFF;
    tick();
    cpu_w = 0;
    n_tests++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL cyc_clear got %h want %h", cpu_rdata, 32'h0); end
    cpu_w = 1; cpu_wflag = 4'hE;
    tick();
    cpu_w = 0;
    n_tests++;
    if (cpu_rdata !== 32'h1) begin n_fail++; $display("FAIL cyc_partial got %h want %h", cpu_rdata, 32'h1); end
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    #1;
    tick();
    n_tests++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap got %h want %h", cpu_rdata, 32'h0); end
  endtask

  task automatic test_reset_mid_settle();
    sw = 16'h00FF;
    tick(); tick(); tick(); tick();
    reset = 1'b1; sw = 16'h0000; cpu_addr = 32'h1002_0008;
    tick();
    n_tests++;
    if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL rst_mid_sw got %h want %h", sw_stable, 16'h0); end
    n_tests++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_cyc got %h want %h", cpu_rdata, 32'h0); end
    for (int k = 0; k < 8; k++) tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_tests++;
    if (sw_stable !== 16'h0) begin n_fail++; $display("FAIL rst_abandon got %h want %h", sw_stable, 16'h0); end
    n_tests++;
    if (cpu_rdata !== 32'd10) begin n_fail++; $display("FAIL rst_cyc_run got %h want %h", cpu_rdata, 32'd10); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_seg_write();
    test_partial_and_reserved();
    test_alias_and_rw_same();
    test_glitch();
    test_debounce_step();
    test_cycle();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_ctrl.md
Name: io_ctrl

Overview:
- Memory-mapped I/O controller between the single-cycle CPU data port and the data memory.
- Decodes each CPU data access:
  - accesses outside the I/O window pass through to dmem;
  - accesses inside the window hit three local registers: 7-segment display value, debounced switches, free-running cycle counter.
- Drives the display value to the downstream seg7x16 scanner and returns read data to the CPU in the same cycle.

Parameters:
- IO_BASE_HI, 16'h1002, value of addr[31:16] that selects the I/O window.
- DEB_CYCLES, 20'd1000000, cycles switch input must be stable before it is committed; minimum 2.
- SW_W, 16, switch vector width.

Ports:
- clk_in  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_addr  input  32  CPU data address (ALU_out).
- cpu_wdata  input  32  CPU store data.
- cpu_w  input  1  CPU store strobe.
- cpu_r  input  1  CPU load strobe.
- cpu_wflag  input  4  byte-lane write mask from CPU.
- cpu_rdata  output  32  load data to CPU.
- dm_w  output  1  gated store strobe to dmem.
- dm_r  output  1  gated load strobe to dmem.
- dm_rdata  input  32  dmem read data.
- sw  input  SW_W  raw asynchronous switches.
- seg_data  output  32  value for seg7x16.
- sw_stable  output  SW_W  debounced switch value.

Behaviour:
- Address decode:
  - io_hit = (cpu_addr[31:16] == IO_BASE_HI); combinational.
  - Register offset = cpu_addr[3:2]; cpu_addr[15:4] and cpu_addr[1:0] are ignored, so the window aliases every 16 bytes.
- dmem gating:
  - dm_w = cpu_w & ~io_hit.
  - dm_r = cpu_r & ~io_hit.
- Register map (offset field):
  - 0 SEG: read/write.
  - 1 SW: read-only; read returns zero-extended sw_stable.
  - 2 CYC: read; a write of any value clears it.
  - 3: reads 32'h0, writes ignored.
- Write rules:
  - An I/O write takes effect at the rising edge where cpu_w=1, io_hit=1 and cpu_wflag==4'hF.
  - Partial-lane I/O writes (any other cpu_wflag) are ignored, with no side effects.
- Reads:
  - cpu_rdata is combinational: the selected I/O register when io_hit, dm_rdata otherwise.
  - cpu_rdata reflects register contents before the current edge (no write-through within the cycle).
  - cpu_r is not required for I/O reads; the mux is driven by the address only. Reads have no side effects.
- Cycle counter CYC:
  - Increments by 1 every cycle; wraps 32'hFFFFFFFF to 0.
  - A full-word write to offset 2 forces it to 0 on that edge; the clear takes priority over the increment.
- Switch path:
  - Two-flop synchronizer: sw_s1, then sw_s2.
  - Debounce FSM with states IDLE and SETTLING:
    - IDLE: if sw_s2 != sw_stable, load cand <= sw_s2 and cnt <= 0, go to SETTLING.
    - SETTLING:
      - if sw_s2 != cand, reload cand <= sw_s2, cnt <= 0, stay;
      - else if cnt == DEB_CYCLES-1, sw_stable <= cand, go to IDLE;
      - else cnt <= cnt+1.
    - A change that returns to the old stable value before commit still commits that value; this is harmless.
  - Latency from a stable raw change to sw_stable: 2 (sync) + 1 (IDLE detect) + DEB_CYCLES cycles.
- Reset, synchronous:
  - seg_data=0, sw_stable=0, CYC=0.
  - sw_s1=0, sw_s2=0, cand=0, cnt=0, FSM in IDLE.
  - Reset asserted mid-settle abandons the pending commit.
  - Reset has priority over all writes.
- Simultaneous cpu_w and cpu_r both high: the write is applied at the edge; the read returns the pre-edge value.

Decomposition:
- Package io_pkg holds:
  - offset constants OFF_SEG=2'd0, OFF_SW=2'd1, OFF_CYC=2'd2;
  - FSM state encoding IDLE/SETTLING;
  - full-word mask constant 4'hF.
- Sub-module sw_debounce: synchronizer + FSM + counter, parameterised by SW_W and DEB_CYCLES.
- Top io_ctrl keeps the decode, register file, counter and read mux.

Test Plan:
- Reset, then cpu_addr=32'h10010000, cpu_w=1, cpu_wflag=4'hF -> dm_w=1, seg_data stays 0; cpu_rdata equals dm_rdata.
- Write 32'h12345678 to 32'h10020000 with wflag=4'hF -> dm_w=0, seg_data=32'h12345678 next cycle; a read of 32'h10020000 returns 32'h12345678.
- Same write with wflag=4'h3 -> seg_data unchanged, dm_w=0.
- DEB_CYCLES=4:
  - sw steps 0 to 16'hA5A5 and holds -> sw_stable=16'hA5A5 exactly 7 cycles after the step edge;
  - a read of 32'h10020004 then returns 32'h0000A5A5.
- DEB_CYCLES=4, sw glitches to 16'h0001 for 2 cycles then returns to 0 -> sw_stable stays 0 throughout.
- Read 32'h10020008 on two consecutive cycles -> values differ by 1.
  - Write to offset 8 -> next-cycle read returns 0.
  - Counter preloaded via force to 32'hFFFFFFFF -> wraps to 0.
  - Reset held high mid-settle -> sw_stable=0, counter=0.
